// File: rtl/systolic_array_2x2.sv
// Weight-stationary 2x2 systolic matrix-multiply tile.
// Weights shift in from the top while sa_load=1; activations stream in from
// the left and partial sums flow down to the bottom edge while sa_load=0.
// Optional build macro: SA_SATURATE_EN (psum update saturates instead of wrapping).
module systolic_array_2x2 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  sa_clk,
    input  logic                  sa_rst,
    input  logic                  sa_load,
    input  logic [DATA_WIDTH-1:0] sa_RD_0,
    input  logic [DATA_WIDTH-1:0] sa_RD_1,
    input  logic [DATA_WIDTH-1:0] sa_FDi_0,
    input  logic [DATA_WIDTH-1:0] sa_FDi_1,
    input  logic                  sa_bd_PE_0,
    input  logic                  sa_bd_PE_1,
    output logic [DATA_WIDTH-1:0] sa_GD_0,
    output logic [DATA_WIDTH-1:0] sa_GD_1,
    output logic [DATA_WIDTH-1:0] sa_FDo_0,
    output logic [DATA_WIDTH-1:0] sa_FDo_1
);

    localparam int DW = DATA_WIDTH;

    // Per-PE state, indexed [row][col]
    logic [1:0][1:0][DW-1:0] w_q;
    logic [1:0][1:0][DW-1:0] a_q;
    logic [1:0][1:0][DW-1:0] p_q;

    // Per-PE next-state terms
    logic [1:0][1:0][DW-1:0] a_in;
    logic [1:0][1:0][DW-1:0] p_in;
    logic [1:0][1:0][DW-1:0] p_nxt;

    // Edge inputs gathered into index-friendly vectors
    logic [1:0][DW-1:0] rd;
    logic [1:0][DW-1:0] fdi;
    logic [1:0]         bd;

    assign rd  = {sa_RD_1, sa_RD_0};
    assign fdi = {sa_FDi_1, sa_FDi_0};
    assign bd  = {sa_bd_PE_1, sa_bd_PE_0};

    // Multiply-accumulate for one PE: psum + act * wt, unsigned
    function automatic logic [DW-1:0] mac(input logic [DW-1:0] psum,
                                          input logic [DW-1:0] act,
                                          input logic [DW-1:0] wt);
`ifdef SA_SATURATE_EN
        logic [2*DW-1:0] prod;
        logic [DW:0]     sum;
        prod = {{DW{1'b0}}, act} * {{DW{1'b0}}, wt};
        sum  = {1'b0, psum} + {1'b0, prod[DW-1:0]};
        // Clamp when either the product or the accumulation leaves DW bits
        if ((|prod[2*DW-1:DW]) || sum[DW]) begin
            return '1;
        end
        return sum[DW-1:0];
`else
        logic [DW-1:0] prod;
        prod = act * wt;
        return psum + prod;
`endif
    endfunction

    // Activation routing, psum routing with boundary forcing, and MAC results
    always_comb begin
        // NOTE: every array element is written on every pass through this block, so no latch can be inferred.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                a_in[r][c]  = (c == 0) ? fdi[r] : a_q[r][0];
                p_in[r][c]  = (bd[r] || (r == 0)) ? '0 : p_q[0][c];
                p_nxt[r][c] = mac(p_in[r][c], a_in[r][c], w_q[r][c]);
            end
        end
    end

    // PE registers: weight shift in load mode, activation/psum advance in compute mode
    always_ff @(posedge sa_clk or negedge sa_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every PE samples its neighbours' pre-edge values.
        if (!sa_rst) begin
            // NOTE: the weight array is reset along with the datapath; a reset therefore always forces a weight reload.
            w_q <= '0;
            a_q <= '0;
            p_q <= '0;
        end else if (sa_load) begin
            w_q[0] <= rd;
            w_q[1] <= w_q[0];
            a_q    <= '0;
            p_q    <= '0;
        end else begin
            a_q <= a_in;
            p_q <= p_nxt;
        end
    end

    assign sa_GD_0  = p_q[1][0];
    assign sa_GD_1  = p_q[1][1];
    assign sa_FDo_0 = a_q[0][1];
    assign sa_FDo_1 = a_q[1][1];

endmodule

// File: tb/tb_systolic_array_2x2.sv
// Self-checking bench for systolic_array_2x2: a per-cycle vector table for
// load + single activation, plus hand sequences for matmul, boundary flags,
// overflow and asynchronous reset.
module tb_systolic_array_2x2;

    localparam int DW = 16;

    logic          sa_clk;
    logic          sa_rst;
    logic          sa_load;
    logic [DW-1:0] sa_RD_0, sa_RD_1, sa_FDi_0, sa_FDi_1;
    logic          sa_bd_PE_0, sa_bd_PE_1;
    logic [DW-1:0] sa_GD_0, sa_GD_1, sa_FDo_0, sa_FDo_1;

    int n_checks = 0;
    int n_errors = 0;

    systolic_array_2x2 #(.DATA_WIDTH(DW)) dut (
        .sa_clk     (sa_clk),
        .sa_rst     (sa_rst),
        .sa_load    (sa_load),
        .sa_RD_0    (sa_RD_0),
        .sa_RD_1    (sa_RD_1),
        .sa_FDi_0   (sa_FDi_0),
        .sa_FDi_1   (sa_FDi_1),
        .sa_bd_PE_0 (sa_bd_PE_0),
        .sa_bd_PE_1 (sa_bd_PE_1),
        .sa_GD_0    (sa_GD_0),
        .sa_GD_1    (sa_GD_1),
        .sa_FDo_0   (sa_FDo_0),
        .sa_FDo_1   (sa_FDo_1)
    );

    initial sa_clk = 1'b0;
    always #5 sa_clk = ~sa_clk;

    typedef struct {
        logic          load;
        logic [DW-1:0] rd0, rd1, fdi0, fdi1;
        logic          bd0, bd1;
        logic [DW-1:0] gd0, gd1, fdo0, fdo1;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge sa_clk);
        #1;
    endtask

    task automatic drive(input logic load, input logic [DW-1:0] rd0, input logic [DW-1:0] rd1,
                         input logic [DW-1:0] fdi0, input logic [DW-1:0] fdi1,
                         input logic bd0, input logic bd1);
        sa_load    = load;
        sa_RD_0    = rd0;
        sa_RD_1    = rd1;
        sa_FDi_0   = fdi0;
        sa_FDi_1   = fdi1;
        sa_bd_PE_0 = bd0;
        sa_bd_PE_1 = bd1;
    endtask

    // Two load edges: first pair ends in row 1, second pair in row 0
    task automatic load_weights(input logic [DW-1:0] f0, input logic [DW-1:0] f1,
                                input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        drive(1'b1, f0, f1, '0, '0, 1'b1, 1'b0);
        step();
        drive(1'b1, s0, s1, '0, '0, 1'b1, 1'b0);
        step();
    endtask

    task automatic check_outs(input string tag, input logic [DW-1:0] gd0, input logic [DW-1:0] gd1,
                              input logic [DW-1:0] fdo0, input logic [DW-1:0] fdo1);
        check({tag, ".GD_0"},  sa_GD_0,  gd0);
        check({tag, ".GD_1"},  sa_GD_1,  gd1);
        check({tag, ".FDo_0"}, sa_FDo_0, fdo0);
        check({tag, ".FDo_1"}, sa_FDo_1, fdo1);
    endtask

    logic [DW-1:0] exp_ovf;

    initial begin
`ifdef SA_SATURATE_EN
        exp_ovf = 16'hFFFF;
`else
        exp_ovf = 16'hFFFE;
`endif
        // load, rd0, rd1, fdi0, fdi1, bd0, bd1 | gd0, gd1, fdo0, fdo1 (after the edge)
        tbl[0] = '{1'b1, 16'd1, 16'd2, 16'd0, 16'd0, 1'b1, 1'b0, 16'd0,  16'd0,  16'd0, 16'd0};
        tbl[1] = '{1'b1, 16'd3, 16'd4, 16'd0, 16'd0, 1'b1, 1'b0, 16'd0,  16'd0,  16'd0, 16'd0};
        tbl[2] = '{1'b0, 16'd0, 16'd0, 16'd5, 16'd0, 1'b1, 1'b0, 16'd0,  16'd0,  16'd0, 16'd0};
        tbl[3] = '{1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 16'd15, 16'd0,  16'd5, 16'd0};
        tbl[4] = '{1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 16'd0,  16'd20, 16'd0, 16'd0};
        tbl[5] = '{1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 16'd0,  16'd0,  16'd0, 16'd0};

        // Power-on reset
        sa_rst = 1'b0;
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        #12;
        check_outs("por", '0, '0, '0, '0);
        sa_rst = 1'b1;
        #1;

        // Load (1,2) then (3,4), then a single activation of 5 on row 0
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].load, tbl[i].rd0, tbl[i].rd1, tbl[i].fdi0, tbl[i].fdi1, tbl[i].bd0, tbl[i].bd1);
            step();
            check_outs($sformatf("vec%0d", i), tbl[i].gd0, tbl[i].gd1, tbl[i].fdo0, tbl[i].fdo1);
        end

        // Matmul, rows 0/1 holding (3,4)/(1,2); A rows (1,2),(3,4), FDi_1 skewed one cycle
        load_weights(16'd1, 16'd2, 16'd3, 16'd4);
        drive(1'b0, '0, '0, 16'd1, 16'd0, 1'b1, 1'b0); step();
        drive(1'b0, '0, '0, 16'd3, 16'd2, 1'b1, 1'b0); step();
        check("mm1.GD_0.t0", sa_GD_0, 16'd5);
        drive(1'b0, '0, '0, 16'd0, 16'd4, 1'b1, 1'b0); step();
        check("mm1.GD_0.t1", sa_GD_0, 16'd13);
        check("mm1.GD_1.t0", sa_GD_1, 16'd8);
        check("mm1.FDo_1.t0", sa_FDo_1, 16'd2);
        drive(1'b0, '0, '0, 16'd0, 16'd0, 1'b1, 1'b0); step();
        check("mm1.GD_1.t1", sa_GD_1, 16'd20);
        check("mm1.FDo_1.t1", sa_FDo_1, 16'd4);

        // Matmul with W=[[1,2],[3,4]] in rows 0/1 -> C=[[7,10],[15,22]]
        load_weights(16'd3, 16'd4, 16'd1, 16'd2);
        drive(1'b0, '0, '0, 16'd1, 16'd0, 1'b1, 1'b0); step();
        drive(1'b0, '0, '0, 16'd3, 16'd2, 1'b1, 1'b0); step();
        check("mm2.GD_0.t0", sa_GD_0, 16'd7);
        drive(1'b0, '0, '0, 16'd0, 16'd4, 1'b1, 1'b0); step();
        check("mm2.GD_0.t1", sa_GD_0, 16'd15);
        check("mm2.GD_1.t0", sa_GD_1, 16'd10);
        drive(1'b0, '0, '0, 16'd0, 16'd0, 1'b1, 1'b0); step();
        check("mm2.GD_1.t1", sa_GD_1, 16'd22);

        // Row-1 boundary discards the row-0 psum
        load_weights(16'd1, 16'd2, 16'd3, 16'd4);
        drive(1'b0, '0, '0, 16'd5, 16'd0, 1'b1, 1'b1); step();
        drive(1'b0, '0, '0, 16'd0, 16'd0, 1'b1, 1'b1); step();
        check("bd1.GD_0", sa_GD_0, 16'd0);
        check("bd1.FDo_0", sa_FDo_0, 16'd5);
        step();
        check("bd1.GD_1", sa_GD_1, 16'd0);

        // Boundary flag changing per cycle: first psum blocked, second passed
        load_weights(16'd1, 16'd2, 16'd3, 16'd4);
        drive(1'b0, '0, '0, 16'd5, 16'd0, 1'b0, 1'b1); step();
        drive(1'b0, '0, '0, 16'd2, 16'd0, 1'b0, 1'b1); step();
        check("bdsw.GD_0.blocked", sa_GD_0, 16'd0);
        drive(1'b0, '0, '0, 16'd0, 16'd0, 1'b0, 1'b0); step();
        check("bdsw.GD_0.passed", sa_GD_0, 16'd6);

        // Product overflow: 2 * 0xFFFF in row 1 alone
        load_weights(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        drive(1'b0, '0, '0, 16'd0, 16'd2, 1'b1, 1'b1); step();
        check("ovf.prod.GD_0", sa_GD_0, exp_ovf);
        // Sum overflow: 0xFFFF from row 0 plus 1 * 0xFFFF in row 1
        load_weights(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        drive(1'b0, '0, '0, 16'd1, 16'd0, 1'b1, 1'b0); step();
        drive(1'b0, '0, '0, 16'd0, 16'd1, 1'b1, 1'b0); step();
        check("ovf.sum.GD_0", sa_GD_0, exp_ovf);

        // Asynchronous reset mid-run
        load_weights(16'd1, 16'd2, 16'd3, 16'd4);
        drive(1'b0, '0, '0, 16'd5, 16'd0, 1'b1, 1'b0); step();
        drive(1'b0, '0, '0, 16'd5, 16'd0, 1'b1, 1'b0); step();
        check("pre_rst.GD_0", sa_GD_0, 16'd15);
        #2;
        sa_rst = 1'b0;
        #1;
        check_outs("rst_async", '0, '0, '0, '0);
        drive(1'b0, '0, '0, 16'd0, 16'd0, 1'b1, 1'b0);
        step();
        sa_rst = 1'b1;
        step();
        check_outs("post_rst.e1", '0, '0, '0, '0);
        step();
        check_outs("post_rst.e2", '0, '0, '0, '0);
        // Weights were cleared: activation passes through but psums stay 0
        drive(1'b0, '0, '0, 16'd5, 16'd0, 1'b1, 1'b0); step();
        drive(1'b0, '0, '0, 16'd0, 16'd0, 1'b1, 1'b0); step();
        check("post_rst.GD_0", sa_GD_0, 16'd0);
        check("post_rst.FDo_0", sa_FDo_0, 16'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
